// File: rtl/step_ctrl.sv
// Step-pulse controller: paced one-clock enable pulses to an up/down counter, with abort.
// Optional reversal dead-time is built when STEP_CTRL_DEADTIME_EN is defined.
module step_ctrl #(
  parameter int unsigned DivW    = 16,
  parameter int unsigned StepsW  = 8,
  parameter int unsigned DeadCyc = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_dir_i,
  input  logic [StepsW-1:0] cmd_steps_i,
  input  logic [DivW-1:0]   cmd_div_i,
  input  logic              stop_i,
  output logic              en_o,
  output logic              dir_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [StepsW-1:0] steps_left_o
);

`ifdef STEP_CTRL_DEADTIME_EN
  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;
  logic [7:0] dead_q, dead_d;
`else
  typedef enum logic [1:0] {StIdle, StRun} state_e;
  logic unused_dead_cyc;
  assign unused_dead_cyc = ^DeadCyc;
`endif

  state_e            state_q, state_d;
  logic              en_q, en_d;
  logic              dir_q, dir_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [StepsW-1:0] steps_q, steps_d;
  logic [DivW-1:0]   reload_q, reload_d;
  logic [DivW-1:0]   div_q, div_d;

  always_comb begin
    state_d   = state_q;
    en_d      = 1'b0;
    dir_d     = dir_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    steps_d   = steps_q;
    reload_d  = reload_q;
    div_d     = div_q;
`ifdef STEP_CTRL_DEADTIME_EN
    dead_d    = dead_q;
`endif
    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          steps_d  = cmd_steps_i;
          reload_d = cmd_div_i;
          div_d    = cmd_div_i;
          dir_d    = cmd_dir_i;
          state_d  = StRun;
`ifdef STEP_CTRL_DEADTIME_EN
          if (cmd_dir_i != dir_q) begin
            state_d = StDead;
            dead_d  = 8'(DeadCyc - 1);
          end
`endif
        end
      end
      StRun: begin
        // An exhausted count completes normally even if stop arrives with the last pulse.
        if (steps_q == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (stop_i) begin
          done_d    = 1'b1;
          aborted_d = 1'b1;
          state_d   = StIdle;
        end else if (div_q == '0) begin
          en_d    = 1'b1;
          steps_d = steps_q - StepsW'(1);
          div_d   = reload_q;
        end else begin
          div_d = div_q - DivW'(1);
        end
      end
`ifdef STEP_CTRL_DEADTIME_EN
      StDead: begin
        if (stop_i) begin
          done_d    = 1'b1;
          aborted_d = 1'b1;
          state_d   = StIdle;
        end else if (dead_q == '0) begin
          state_d = StRun;
        end else begin
          dead_d = dead_q - 8'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      steps_q   <= '0;
      reload_q  <= '0;
      div_q     <= '0;
`ifdef STEP_CTRL_DEADTIME_EN
      dead_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      steps_q   <= steps_d;
      reload_q  <= reload_d;
      div_q     <= div_d;
`ifdef STEP_CTRL_DEADTIME_EN
      dead_q    <= dead_d;
`endif
    end
  end

  assign cmd_ready_o  = (state_q == StIdle) && !rst_i;
  assign busy_o       = (state_q != StIdle);
  assign en_o         = en_q;
  assign dir_o        = dir_q;
  assign done_o       = done_q;
  assign aborted_o    = aborted_q;
  assign steps_left_o = steps_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl; expected traces are hand-computed relative to the acceptance edge.
module tb_step_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_dir, stop;
  logic [7:0]  cmd_steps;
  logic [15:0] cmd_div;
  logic        en, dir, busy, done, aborted;
  logic [7:0]  steps_left;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] en_tr, done_tr, ab_tr, rdy_tr, dir_tr;
  logic [7:0]  sl_tr [64];

  always #5 clk = ~clk;

  step_ctrl #(.DivW(16), .StepsW(8), .DeadCyc(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_dir_i    (cmd_dir),
    .cmd_steps_i  (cmd_steps),
    .cmd_div_i    (cmd_div),
    .stop_i       (stop),
    .en_o         (en),
    .dir_o        (dir),
    .busy_o       (busy),
    .done_o       (done),
    .aborted_o    (aborted),
    .steps_left_o (steps_left)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
  endtask

  // Presents a command at the falling edge; returns 1 ns after the acceptance edge.
  task automatic issue(input logic d, input logic [7:0] s, input logic [15:0] v);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_steps = s;
    cmd_div   = v;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Bit k of each trace holds the output sampled after the k-th edge from now.
  task automatic capture(input int n);
    en_tr = '0; done_tr = '0; ab_tr = '0; rdy_tr = '0; dir_tr = '0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      en_tr[k]   = en;
      done_tr[k] = done;
      ab_tr[k]   = aborted;
      rdy_tr[k]  = cmd_ready;
      dir_tr[k]  = dir;
      sl_tr[k]   = steps_left;
    end
  endtask

  initial begin
    int pulses;
    int hit;
    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; cmd_div = '0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("ready_in_rst", cmd_ready, 0);
    check_eq("busy_in_rst", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", cmd_ready, 1);
    check_eq("rst_state", {en, dir, done, aborted, steps_left}, 0);

    // stop in idle is ignored
    @(negedge clk); stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    check_eq("idle_stop", {busy, done, aborted}, 0);

    // 3 steps, div 2: en at +3,+6,+9, done at +10
    issue(1'b0, 8'd3, 16'd2);
    check_eq("m1_accept", {busy, cmd_ready, steps_left}, {1'b1, 1'b0, 8'd3});
    capture(12);
    check_eq("m1_en", en_tr, 64'h248);
    check_eq("m1_done", done_tr, 64'h400);
    check_eq("m1_abort", ab_tr, 0);
    check_eq("m1_ready", rdy_tr[10], 1);

    // 5 steps, div 0: en every clock
    issue(1'b0, 8'd5, 16'd0);
    check_eq("m2_sl0", steps_left, 5);
    capture(7);
    check_eq("m2_en", en_tr, 64'h3e);
    check_eq("m2_sl1", sl_tr[1], 4);
    check_eq("m2_sl5", sl_tr[5], 0);
    check_eq("m2_done", done_tr, 64'h40);

    // 0 steps: done next clock, no en
    issue(1'b0, 8'd0, 16'd5);
    capture(3);
    check_eq("m3_en", en_tr, 0);
    check_eq("m3_done", done_tr, 64'h2);
    check_eq("m3_ready", rdy_tr[1], 1);

    // command while busy is neither taken nor queued
    issue(1'b0, 8'd2, 16'd3);
    cmd_valid = 1'b1; cmd_steps = 8'd9;
    capture(2);
    cmd_valid = 1'b0;
    check_eq("busy_ignore_sl", sl_tr[2], 2);
    capture(9);
    check_eq("busy_ignore_done", done_tr, 64'h80);
    check_eq("busy_ignore_idle", busy, 0);

    // 10 steps, div 1, stop raised while 4th pulse is visible
    issue(1'b0, 8'd10, 16'd1);
    pulses = 0; hit = 0;
    for (int k = 1; k <= 20 && hit == 0; k++) begin
      @(posedge clk); #1;
      if (en) pulses++;
      if (pulses == 4) hit = k;
    end
    check_eq("m4_pulse4_at", hit, 8);
    stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    check_eq("m4_abort", {en, busy, done, aborted, steps_left}, {4'b0011, 8'd6});
    capture(5);
    check_eq("m4_no_en", en_tr | done_tr, 0);

    // stop during the final pulse still completes normally
    issue(1'b0, 8'd2, 16'd0);
    capture(2);
    stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    check_eq("m5_final_stop", {done, aborted, steps_left}, {2'b10, 8'd0});
    check_eq("m5_en", en_tr, 64'h6);

    // reversal 0 -> 1
    issue(1'b1, 8'd2, 16'd0);
    capture(8);
    check_eq("m6_dir", dir_tr[1], 1);
`ifdef STEP_CTRL_DEADTIME_EN
    check_eq("m6_en", en_tr, 64'h60);
    check_eq("m6_done", done_tr, 64'h80);
`else
    check_eq("m6_en", en_tr, 64'h6);
    check_eq("m6_done", done_tr, 64'h8);
`endif

    // same direction never waits
    issue(1'b1, 8'd1, 16'd0);
    capture(3);
    check_eq("m7_en", en_tr, 64'h2);
    check_eq("m7_dir_held", dir, 1);

    // reset mid-move
    issue(1'b1, 8'd9, 16'd0);
    capture(2);
    check_eq("m8_sl", sl_tr[2], 7);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check_eq("m8_rst", {en, busy, done, dir, steps_left}, 0);
    capture(3);
    check_eq("m8_quiet", en_tr | done_tr, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter DIV_W, default 16: width of step-rate divider.
REQ-002 Parameter STEPS_W, default 8: width of step count.
REQ-003 Parameter DEAD_CYC, default 4: reversal dead-time in clocks (1..255).
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  move command offered.
REQ-007 cmd_ready  output  1  controller can accept a command; combinational, equals (state==IDLE && !rst).
REQ-008 cmd_dir  input  1  0 = up/clockwise, 1 = down/counter-clockwise.
REQ-009 cmd_steps  input  STEPS_W  number of en pulses to issue.
REQ-010 cmd_div  input  DIV_W  pulse spacing minus one, in clocks.
REQ-011 stop  input  1  abort the current move.
REQ-012 en  output  1  registered one-clock step-enable to the up/down counter.
REQ-013 dir  output  1  registered direction to the counter.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-clock completion pulse.
REQ-016 aborted  output  1  valid with done; 1 = move ended by stop.
REQ-017 steps_left  output  STEPS_W  pulses still to issue.

Function
REQ-018 FSM states IDLE, DEAD, RUN; command accepted on a rising edge with cmd_valid && cmd_ready.
REQ-019 On acceptance, latch cmd_steps into steps_left and cmd_div into the divider reload, then go to RUN (or DEAD per REQ-030).
REQ-020 In RUN, divider counts down from reload; en=1 for exactly one clock when divider reaches 0, with steps_left decremented in the same edge and divider reloaded.
REQ-021 First en pulse in cycle acceptance+1+cmd_div; subsequent pulses spaced cmd_div+1 clocks; cmd_div=0 gives en every clock.
REQ-022 Clock after the final en pulse: done=1, aborted=0, state IDLE, cmd_ready=1.
REQ-023 cmd_steps=0: no en pulse; done=1 in the clock after acceptance.
REQ-024 stop=1 sampled in RUN or DEAD: no en from the next clock; next clock done=1, aborted=1, steps_left holds remaining count, state IDLE.
REQ-025 stop coinciding with the final en pulse: pulse counts, aborted=0.
REQ-026 stop in IDLE ignored; cmd_valid while busy ignored, not queued.
REQ-027 dir changes only on acceptance; stable while busy; held after done.
REQ-028 en never asserted in IDLE or DEAD.

Reset
REQ-029 rst=1 at a rising edge: state IDLE, en=0, dir=0, busy=0, done=0, aborted=0, steps_left=0, divider=0, mid-move pulses cease from next clock without done.

Configuration
REQ-030 Macro STEP_CTRL_DEADTIME_EN defined: acceptance with cmd_dir != current dir enters DEAD for DEAD_CYC clocks (en=0, dir already updated), then RUN; first en delayed by DEAD_CYC clocks; same-direction commands skip DEAD.
REQ-031 Macro undefined: DEAD state absent; every accepted command goes directly to RUN; DEAD_CYC unused.

Verification
REQ-032 Reset, then cmd_steps=3, cmd_div=2, cmd_dir=0 -> en at acceptance+3, +6, +9; done at +10, aborted=0.
REQ-033 cmd_steps=5, cmd_div=0 -> en high 5 consecutive clocks, steps_left 5..0, done next clock.
REQ-034 cmd_steps=0 -> no en, done=1 at acceptance+1, cmd_ready=1 same clock.
REQ-035 cmd_steps=10, cmd_div=1, stop after 4th pulse -> no further en, done=1, aborted=1, steps_left=6.
REQ-036 With STEP_CTRL_DEADTIME_EN, dir=0 then cmd_dir=1, cmd_div=0 -> dir=1 at acceptance+1, first en at acceptance+1+4; without macro first en at acceptance+1.
REQ-037 rst asserted mid-move (steps_left=7) -> next clock en=0, busy=0, steps_left=0, dir=0, no done pulse.
